// File: rtl/t_ff_bank.sv
// Bank of WIDTH clocked toggle flip-flops with four runtime modes:
// per-bit T, shared-control JK, up/down counter built as a T-FF chain, and
// parallel load. It also provides a complementary output, a registered
// per-bit change mask and a one-cycle counter wrap flag.

module t_ff_bank #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] changed,
  output logic             wrap
);

  typedef enum logic [1:0] {
    ModeT     = 2'b00,
    ModeJk    = 2'b01,
    ModeCount = 2'b10,
    ModeLoad  = 2'b11
  } mode_e;

  mode_e            mode_sel;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] changed_q;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] cnt_toggle;
  logic             chain;

  assign mode_sel = mode_e'(mode);

  // T-FF chain toggle mask: bit i toggles when all lower bits are 1 (up) or
  // 0 (down). The carry left over after the top bit marks a wrap.
  always_comb begin
    cnt_toggle = '0;
    chain      = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_toggle[i] = chain;
      chain         = chain & (up ? q_q[i] : ~q_q[i]);
    end
  end

  // Next-state selection; en=0 holds and suppresses wrap.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (en) begin
      unique case (mode_sel)
        ModeT:     q_d = q_q ^ t;
        ModeJk:    q_d = (j & ~q_q) | (~k & q_q);
        ModeCount: begin
          q_d    = q_q ^ cnt_toggle;
          wrap_d = chain;
        end
        ModeLoad:  q_d = d;
        default:   q_d = q_q;
      endcase
    end
  end

  // State register with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q       <= RESET_VAL;
      changed_q <= '0;
      wrap_q    <= 1'b0;
    end else begin
      q_q       <= q_d;
      changed_q <= q_d ^ q_q;
      wrap_q    <= wrap_d;
    end
  end

  // qbar derives from the same register so it can never disagree with q.
  assign q       = q_q;
  assign qbar    = ~q_q;
  assign changed = changed_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_t_ff_bank.sv
// Directed and random checks for t_ff_bank with WIDTH=8, RESET_VAL=8'hA5.

module tb_t_ff_bank;

  localparam int unsigned W = 8;
  localparam logic [W-1:0] RV = 8'hA5;

  logic         clk = 1'b0;
  logic         rst_n, en, up;
  logic [1:0]   mode;
  logic [W-1:0] t, j, k, d;
  logic [W-1:0] q, qbar, changed;
  logic         wrap;

  int vectors = 0;
  int errors  = 0;

  t_ff_bank #(
    .WIDTH     (W),
    .RESET_VAL (RV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .t       (t),
    .j       (j),
    .k       (k),
    .up      (up),
    .d       (d),
    .q       (q),
    .qbar    (qbar),
    .changed (changed),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] val);
    rst_n = 1'b1; en = 1'b1; mode = 2'b11; d = val;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 2'b10; up = 1'b1;
    step(); step();
    vectors++; if (q !== 8'hA5) begin errors++; $display("FAIL reset_q got %h exp a5", q); end
    vectors++; if (qbar !== 8'h5A) begin errors++; $display("FAIL reset_qbar got %h exp 5a", qbar); end
    vectors++; if (changed !== 8'h00) begin errors++; $display("FAIL reset_changed got %h exp 00", changed); end
    vectors++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b exp 0", wrap); end
    rst_n = 1'b1; en = 1'b0;
    step();
    vectors++; if (q !== 8'hA5) begin errors++; $display("FAIL hold_q got %h exp a5", q); end
    vectors++; if (changed !== 8'h00) begin errors++; $display("FAIL hold_changed got %h exp 00", changed); end
  endtask

  task automatic test_t_mode();
    load(8'h00);
    mode = 2'b00; t = 8'h0F;
    step();
    vectors++; if (q !== 8'h0F) begin errors++; $display("FAIL t1_q got %h exp 0f", q); end
    vectors++; if (qbar !== 8'hF0) begin errors++; $display("FAIL t1_qbar got %h exp f0", qbar); end
    vectors++; if (changed !== 8'h0F) begin errors++; $display("FAIL t1_changed got %h exp 0f", changed); end
    step();
    vectors++; if (q !== 8'h00) begin errors++; $display("FAIL t2_q got %h exp 00", q); end
    vectors++; if (qbar !== 8'hFF) begin errors++; $display("FAIL t2_qbar got %h exp ff", qbar); end
    vectors++; if (changed !== 8'h0F) begin errors++; $display("FAIL t2_changed got %h exp 0f", changed); end
  endtask

  task automatic test_jk_mode();
    load(8'hF0);
    mode = 2'b01; j = 8'h0C; k = 8'h30;
    step();
    vectors++; if (q !== 8'hCC) begin errors++; $display("FAIL jk1_q got %h exp cc", q); end
    j = 8'hFF; k = 8'hFF;
    step();
    vectors++; if (q !== 8'h33) begin errors++; $display("FAIL jk2_q got %h exp 33", q); end
    vectors++; if (changed !== 8'hFF) begin errors++; $display("FAIL jk2_changed got %h exp ff", changed); end
    j = 8'h00; k = 8'h00;
    step();
    vectors++; if (q !== 8'h33) begin errors++; $display("FAIL jk_hold_q got %h exp 33", q); end
  endtask

  task automatic test_count();
    load(8'hFE);
    mode = 2'b10; up = 1'b1;
    step();
    vectors++; if (q !== 8'hFF || wrap !== 1'b0) begin errors++; $display("FAIL up1 got q=%h wrap=%b exp ff/0", q, wrap); end
    step();
    vectors++; if (q !== 8'h00 || wrap !== 1'b1) begin errors++; $display("FAIL up2 got q=%h wrap=%b exp 00/1", q, wrap); end
    vectors++; if (changed !== 8'hFF) begin errors++; $display("FAIL up2_changed got %h exp ff", changed); end
    step();
    vectors++; if (q !== 8'h01 || wrap !== 1'b0) begin errors++; $display("FAIL up3 got q=%h wrap=%b exp 01/0", q, wrap); end
    up = 1'b0;
    step();
    vectors++; if (q !== 8'h00 || wrap !== 1'b0) begin errors++; $display("FAIL dn1 got q=%h wrap=%b exp 00/0", q, wrap); end
    step();
    vectors++; if (q !== 8'hFF || wrap !== 1'b1) begin errors++; $display("FAIL dn2 got q=%h wrap=%b exp ff/1", q, wrap); end
    en = 1'b0;
    step();
    vectors++; if (q !== 8'hFF || wrap !== 1'b0) begin errors++; $display("FAIL dn_hold got q=%h wrap=%b exp ff/0", q, wrap); end
  endtask

  task automatic test_load_reset();
    load(8'hFF);
    load(8'h3C);
    vectors++; if (q !== 8'h3C) begin errors++; $display("FAIL load_q got %h exp 3c", q); end
    vectors++; if (changed !== 8'hC3) begin errors++; $display("FAIL load_changed got %h exp c3", changed); end
    rst_n = 1'b0; en = 1'b1; mode = 2'b10; up = 1'b1;
    step();
    vectors++; if (q !== 8'hA5 || changed !== 8'h00) begin
      errors++; $display("FAIL reset_prio got q=%h chg=%h exp a5/00", q, changed);
    end
    rst_n = 1'b1;
  endtask

  // Random sequence against an arithmetic reference model.
  task automatic test_random();
    logic [W-1:0] mq, nq, mchg;
    logic         mw;
    int           bad;
    mq = q; bad = 0;
    for (int n = 0; n < 10000; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      en    = ($urandom_range(0, 4) != 0);
      mode  = 2'($urandom_range(0, 3));
      up    = 1'($urandom);
      t = 8'($urandom); j = 8'($urandom); k = 8'($urandom); d = 8'($urandom);
      if (n % 7 == 0) d = 8'hFF;
      if (n % 11 == 0) d = 8'h00;
      nq = mq; mw = 1'b0;
      if (en) begin
        case (mode)
          2'b00: nq = mq ^ t;
          2'b01: nq = (j & ~mq) | (~k & mq);
          2'b10: begin
            nq = up ? mq + 8'd1 : mq - 8'd1;
            mw = up ? (mq == 8'hFF) : (mq == 8'h00);
          end
          default: nq = d;
        endcase
      end
      mchg = nq ^ mq;
      if (!rst_n) begin nq = RV; mchg = '0; mw = 1'b0; end
      step();
      vectors++;
      if (q !== nq || qbar !== ~q || changed !== mchg || wrap !== mw) begin
        errors++;
        if (bad < 10) $display("FAIL rand[%0d] got q=%h qb=%h chg=%h w=%b exp q=%h chg=%h w=%b",
                               n, q, qbar, changed, wrap, nq, mchg, mw);
        bad++;
      end
      mq = nq;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; up = 1'b0;
    t = '0; j = '0; k = '0; d = '0;
    #1;
    test_reset();
    test_t_mode();
    test_jk_mode();
    test_count();
    test_load_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
